ctrl_sequencer: RTL
===================

# ctrl_sequencer

Parametrised hardwired control unit driving the bus datapath's control inputs. It replaces hand-sequenced control vectors with a Moore FSM that fetches an instruction, decodes the IR fields and executes any register-register ALU, unary or MUL/DIV instruction. Outputs connect directly to the same-named datapath control ports; the datapath's IR value feeds back as `IR`.

## Interface
- `BITS`, 32, datapath and IR width
- `REGISTERS`, 16, number of GPRs; width of `GPRin`/`GPRout`
- `OPW`, 5, opcode field width (IR[BITS-1 -: OPW])
- `RW`, 4, register-field width; Ra, Rb, Rc follow the opcode MSB-first
- `CNTW`, 16, retired-instruction counter width
- `Clock` in 1, single clock; all state changes on rising edge
- `reset` in 1, asynchronous, active-high
- `run` in 1, level; permits fetching the next instruction
- `hold` in 1, freezes state; outputs keep their current value
- `IR` in BITS, instruction register contents from the datapath
- `PCout, MARin, IncPC, RZin, PCin, Read, MDRin, Zlowout, Zhighout, MDRout, IRin, RYin, LOin, HIin` out 1 each, datapath strobes
- `ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEGATE, NOT` out 1 each, ALU op select (at most one high)
- `GPRin`, `GPRout` out REGISTERS, one-hot register enables (at most one bit high)
- `busy` out 1, high in every state except IDLE and HALTED
- `done` out 1, one-cycle pulse on instruction retirement
- `illegal` out 1, sticky until reset
- `instr_count` out CNTW, retired-instruction count

## Operation
- Opcodes: ADD 3, SUB 4, SHR 5, SHL 6, ROR 7, ROL 8, AND 9, OR 10, MUL 14, DIV 15, NEG 16, NOT 17, NOP 26, HALT 27; all others illegal.
- States: IDLE, T0–T6, HALTED. Moore outputs, decoded from the state register and IR fields.
- IDLE: all outputs 0; `run`=1 -> T0.
- T0: PCout, MARin, IncPC, RZin -> T1.
- T1: Zlowout, PCin, Read, MDRin -> T2.
- T2: MDRout, IRin -> T3. IR is sampled from T3 onward only.
- T3 decode:
  - NOP retires -> T0 if `run`, else IDLE.
  - HALT -> HALTED with no retire.
  - Illegal opcode, or a used register index ≥ REGISTERS -> HALTED, `illegal`=1.
  - Otherwise GPRout[Rb], RYin -> T4.
- T4: two-operand ops drive GPRout[Rc]; NEG/NOT drive GPRout[Rb]. The matching op strobe and RZin are high -> T5.
- T5:
  - MUL/DIV: Zlowout, LOin -> T6.
  - Others: Zlowout, GPRin[Ra], retire.
- T6 (MUL/DIV only): Zhighout, HIin, retire.
- Retire:
  - `done` pulses in the retiring state.
  - `instr_count` increments and wraps at 2^CNTW−1 -> 0.
  - Next state is T0 if `run`=1, else IDLE.
- `run` is sampled only in IDLE and at retirement. Deasserting `run` mid-instruction completes that instruction.
- HALTED: exited only by `reset`.
- `hold`=1 blocks every transition, the counter increment and the `done` pulse. Strobes stay asserted; repeated datapath loads are idempotent.

## Timing
- Reset: state IDLE, every output 0, `instr_count`=0, `illegal`=0. The effect is immediate, including mid-instruction; partial datapath writes are not undone.
- One state per cycle when `hold`=0.
- Fetch is 3 cycles; ALU and unary instructions take 6 cycles T0–T5; MUL/DIV take 7; NOP takes 4.
- Back-to-back: retire state is followed directly by T0, with no bubble.
- `done` is high for exactly the retiring cycle and is never asserted with `hold`=1.
- Simultaneous `reset` and `run`: reset wins.

## Structure
- Package `ctrl_pkg`:
  - opcode localparams
  - state enum (IDLE, T0–T6, HALTED)
  - op-to-strobe index constants
- Sub-module `ctrl_decode`: combinational IR -> {op one-hot, is_muldiv, is_unary, is_nop, is_halt, is_illegal, ra, rb, rc}.
- The top holds the FSM, counter and output decode.

## Test plan
- Directed AND: IR=0x4A920000 (AND R5,R2,R4).
  - T3: GPRout=0x0004, RYin=1.
  - T4: GPRout=0x0010, AND=1, RZin=1.
  - T5: GPRin=0x0020, Zlowout=1, `done`=1, `instr_count`=1.
- MUL: IR opcode 14 -> T5 LOin+Zlowout, T6 HIin+Zhighout; GPRin stays 0; 7 cycles total.
- Illegal: opcode 31 at T3 -> HALTED, `illegal`=1, `busy`=0; stays halted with `run`=1 until `reset`.
- Hold: `hold`=1 for 3 cycles in T4 -> strobes unchanged, no state change; resumes to T5 and retires once.
- Run control: `run` dropped during T2 -> instruction completes, then IDLE with all outputs 0.
- Reset: `reset` asserted mid-T4 -> outputs 0 before the next clock edge; IDLE, `instr_count`=0.
- Wrap: CNTW=2 with 5 NOPs -> `instr_count` reads 1.

Source files
------------

// File: rtl/ctrl_sequencer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// ctrl_pkg : opcodes, FSM state encoding and ALU strobe indices for ctrl_sequencer
// Revision : 1.0
//------------------------------------------------------------------------------
package ctrl_pkg;

  localparam int OPC_ADD  = 3;
  localparam int OPC_SUB  = 4;
  localparam int OPC_SHR  = 5;
  localparam int OPC_SHL  = 6;
  localparam int OPC_ROR  = 7;
  localparam int OPC_ROL  = 8;
  localparam int OPC_AND  = 9;
  localparam int OPC_OR   = 10;
  localparam int OPC_MUL  = 14;
  localparam int OPC_DIV  = 15;
  localparam int OPC_NEG  = 16;
  localparam int OPC_NOT  = 17;
  localparam int OPC_NOP  = 26;
  localparam int OPC_HALT = 27;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_HALTED = 4'd8
  } state_t;

  localparam int NUM_OPS = 12;
  localparam int OPI_ADD = 0;
  localparam int OPI_SUB = 1;
  localparam int OPI_SHR = 2;
  localparam int OPI_SHL = 3;
  localparam int OPI_ROR = 4;
  localparam int OPI_ROL = 5;
  localparam int OPI_AND = 6;
  localparam int OPI_OR  = 7;
  localparam int OPI_MUL = 8;
  localparam int OPI_DIV = 9;
  localparam int OPI_NEG = 10;
  localparam int OPI_NOT = 11;

  // Strobe index for an executable opcode, -1 for anything without an ALU op.
  function automatic int op_index(input int opc);
    case (opc)
      OPC_ADD: return OPI_ADD;
      OPC_SUB: return OPI_SUB;
      OPC_SHR: return OPI_SHR;
      OPC_SHL: return OPI_SHL;
      OPC_ROR: return OPI_ROR;
      OPC_ROL: return OPI_ROL;
      OPC_AND: return OPI_AND;
      OPC_OR:  return OPI_OR;
      OPC_MUL: return OPI_MUL;
      OPC_DIV: return OPI_DIV;
      OPC_NEG: return OPI_NEG;
      OPC_NOT: return OPI_NOT;
      default: return -1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// ctrl_sequencer_if : sequencer <-> datapath control bundle
// Revision : 1.0
//------------------------------------------------------------------------------
interface ctrl_sequencer_if #(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16,
  parameter int CNTW      = 16
);
  logic                 run;
  logic                 hold;
  logic [BITS-1:0]      IR;

  logic PCout, MARin, IncPC, RZin, PCin, Read, MDRin;
  logic Zlowout, Zhighout, MDRout, IRin, RYin, LOin, HIin;
  logic ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEGATE, NOT;
  logic [REGISTERS-1:0] GPRin;
  logic [REGISTERS-1:0] GPRout;
  logic                 busy;
  logic                 done;
  logic                 illegal;
  logic [CNTW-1:0]      instr_count;

  modport master (
    input  run, hold, IR,
    output PCout, MARin, IncPC, RZin, PCin, Read, MDRin,
           Zlowout, Zhighout, MDRout, IRin, RYin, LOin, HIin,
           ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEGATE, NOT,
           GPRin, GPRout, busy, done, illegal, instr_count
  );

  modport slave (
    output run, hold, IR,
    input  PCout, MARin, IncPC, RZin, PCin, Read, MDRin,
           Zlowout, Zhighout, MDRout, IRin, RYin, LOin, HIin,
           ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEGATE, NOT,
           GPRin, GPRout, busy, done, illegal, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_sequencer_decode.sv
`default_nettype none
//------------------------------------------------------------------------------
// ctrl_decode : combinational IR field and opcode-class decode
// Revision : 1.0
//------------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16,
  parameter int OPW       = 5,
  parameter int RW        = 4
) (
  input  logic [BITS-1:0]    IR,
  output logic [NUM_OPS-1:0] op_onehot,
  output logic               is_muldiv,
  output logic               is_unary,
  output logic               is_nop,
  output logic               is_halt,
  output logic               is_illegal,
  output logic [RW-1:0]      ra,
  output logic [RW-1:0]      rb,
  output logic [RW-1:0]      rc
);

  logic [OPW-1:0] opcode;
  int             opc;
  int             idx;
  logic           ra_bad, rb_bad, rc_bad;

  always_comb begin
    opcode    = IR[BITS-1 -: OPW];
    ra        = IR[BITS-OPW-1 -: RW];
    rb        = IR[BITS-OPW-RW-1 -: RW];
    rc        = IR[BITS-OPW-2*RW-1 -: RW];
    opc       = int'(opcode);
    idx       = op_index(opc);
    op_onehot = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      op_onehot[i] = (idx == i);
    end
    is_nop    = (opc == OPC_NOP);
    is_halt   = (opc == OPC_HALT);
    is_muldiv = (opc == OPC_MUL) || (opc == OPC_DIV);
    is_unary  = (opc == OPC_NEG) || (opc == OPC_NOT);
    ra_bad    = (int'(ra) >= REGISTERS);
    rb_bad    = (int'(rb) >= REGISTERS);
    rc_bad    = (int'(rc) >= REGISTERS);
    // Unary ops never read Rc, so its field is free to hold anything.
    is_illegal = (idx < 0 && !is_nop && !is_halt) ||
                 (idx >= 0 && (ra_bad || rb_bad || (!is_unary && rc_bad)));
  end

  generate
    if (BITS > OPW + 3*RW) begin : g_unused_low
      logic unused_low_bits;
      assign unused_low_bits = ^IR[BITS-OPW-3*RW-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// ctrl_sequencer : hardwired Moore control FSM (fetch / decode / execute)
// Revision : 1.0
//------------------------------------------------------------------------------
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16,
  parameter int OPW       = 5,
  parameter int RW        = 4,
  parameter int CNTW      = 16
) (
  input  logic               Clock,
  input  logic               reset,
  ctrl_sequencer_if.master   bus
);

  state_t               state;
  state_t               next_state;
  logic [CNTW-1:0]      retired;
  logic                 illegal_flag;
  logic                 retire;
  logic                 done_pulse;

  logic [NUM_OPS-1:0]   op_onehot;
  logic                 is_muldiv, is_unary, is_nop, is_halt, is_illegal;
  logic [RW-1:0]        ra, rb, rc;

  ctrl_decode #(
    .BITS      (BITS),
    .REGISTERS (REGISTERS),
    .OPW       (OPW),
    .RW        (RW)
  ) u_decode (
    .IR         (bus.IR),
    .op_onehot  (op_onehot),
    .is_muldiv  (is_muldiv),
    .is_unary   (is_unary),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .ra         (ra),
    .rb         (rb),
    .rc         (rc)
  );

  function automatic logic [REGISTERS-1:0] reg_onehot(input logic [RW-1:0] idx);
    logic [REGISTERS-1:0] v;
    v = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (int'(idx) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign retire     = (state == ST_T3 && is_nop) ||
                      (state == ST_T5 && !is_muldiv) ||
                      (state == ST_T6);
  assign done_pulse = retire && !bus.hold;

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!bus.hold) begin
      case (state)
        ST_IDLE:   if (bus.run) next_state = ST_T0;
        ST_T0:     next_state = ST_T1;
        ST_T1:     next_state = ST_T2;
        ST_T2:     next_state = ST_T3;
        ST_T3: begin
          if (is_nop)                     next_state = bus.run ? ST_T0 : ST_IDLE;
          else if (is_halt || is_illegal) next_state = ST_HALTED;
          else                            next_state = ST_T4;
        end
        ST_T4:     next_state = ST_T5;
        ST_T5:     next_state = is_muldiv ? ST_T6 : (bus.run ? ST_T0 : ST_IDLE);
        ST_T6:     next_state = bus.run ? ST_T0 : ST_IDLE;
        ST_HALTED: next_state = ST_HALTED;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      retired      <= '0;
      illegal_flag <= 1'b0;
    end else if (!bus.hold) begin
      if (retire) retired <= retired + 1'b1;
      if (state == ST_T3 && is_illegal) illegal_flag <= 1'b1;
    end
  end

  always_comb begin
    bus.PCout    = 1'b0;  bus.MARin   = 1'b0;  bus.IncPC  = 1'b0;
    bus.RZin     = 1'b0;  bus.PCin    = 1'b0;  bus.Read   = 1'b0;
    bus.MDRin    = 1'b0;  bus.Zlowout = 1'b0;  bus.Zhighout = 1'b0;
    bus.MDRout   = 1'b0;  bus.IRin    = 1'b0;  bus.RYin   = 1'b0;
    bus.LOin     = 1'b0;  bus.HIin    = 1'b0;
    bus.ADD      = 1'b0;  bus.SUB     = 1'b0;  bus.SHR    = 1'b0;
    bus.SHL      = 1'b0;  bus.ROR     = 1'b0;  bus.ROL    = 1'b0;
    bus.AND      = 1'b0;  bus.OR      = 1'b0;  bus.MUL    = 1'b0;
    bus.DIV      = 1'b0;  bus.NEGATE  = 1'b0;  bus.NOT    = 1'b0;
    bus.GPRin    = '0;
    bus.GPRout   = '0;
    case (state)
      ST_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.RZin = 1'b1;
      end
      ST_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      ST_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      ST_T3: begin
        if (!(is_nop || is_halt || is_illegal)) begin
          bus.GPRout = reg_onehot(rb);
          bus.RYin   = 1'b1;
        end
      end
      ST_T4: begin
        bus.GPRout = is_unary ? reg_onehot(rb) : reg_onehot(rc);
        bus.RZin   = 1'b1;
        bus.ADD    = op_onehot[OPI_ADD];
        bus.SUB    = op_onehot[OPI_SUB];
        bus.SHR    = op_onehot[OPI_SHR];
        bus.SHL    = op_onehot[OPI_SHL];
        bus.ROR    = op_onehot[OPI_ROR];
        bus.ROL    = op_onehot[OPI_ROL];
        bus.AND    = op_onehot[OPI_AND];
        bus.OR     = op_onehot[OPI_OR];
        bus.MUL    = op_onehot[OPI_MUL];
        bus.DIV    = op_onehot[OPI_DIV];
        bus.NEGATE = op_onehot[OPI_NEG];
        bus.NOT    = op_onehot[OPI_NOT];
      end
      ST_T5: begin
        bus.Zlowout = 1'b1;
        if (is_muldiv) bus.LOin  = 1'b1;
        else           bus.GPRin = reg_onehot(ra);
      end
      ST_T6: begin
        bus.Zhighout = 1'b1; bus.HIin = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy    = (state != ST_IDLE) && (state != ST_HALTED);
  assign bus.done    = done_pulse;
  assign bus.illegal = illegal_flag;
  // The retiring instruction is already counted during its own retire cycle.
  assign bus.instr_count = retired + {{(CNTW-1){1'b0}}, done_pulse};

endmodule
`default_nettype wire
